calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum cycles spent in COMPUTE waiting for alu_done (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising edge of clk.
REQ-004 btn_clr_pulse  input  1  debounced one-cycle clear pulse.
REQ-005 btn_ent_pulse  input  1  debounced one-cycle enter pulse.
REQ-006 sld_digit_pulse  input  4  debounced one-cycle pulses; bit i increments BCD digit i (bit 0 = least significant digit).
REQ-007 sld_arith_pulse  input  1  debounced one-cycle pulse; toggles operation.
REQ-008 alu_done  input  1  ALU completion strobe.
REQ-009 alu_result  input  16  4-digit BCD result, valid when alu_done=1.
REQ-010 alu_overflow  input  1  ALU overflow/underflow flag, valid when alu_done=1.
REQ-011 operand_a  output  16  latched 4-digit BCD operand A.
REQ-012 operand_b  output  16  latched 4-digit BCD operand B.
REQ-013 op_sub  output  1  0 = add, 1 = subtract.
REQ-014 alu_start  output  1  one-cycle start strobe to ALU.
REQ-015 display_value  output  16  4-digit BCD value for the display driver.
REQ-016 state  output  2  current FSM state encoding.
REQ-017 error  output  1  sticky error flag (ALU overflow or timeout).

Function
REQ-018 FSM states SHALL be ENTRY_A=0, ENTRY_B=1, COMPUTE=2, RESULT=3.
REQ-019 Internal 16-bit BCD entry register; in ENTRY_A/ENTRY_B, each asserted sld_digit_pulse bit increments its digit mod 10 (9 -> 0, no carry into neighbour), visible next cycle.
REQ-020 Multiple sld_digit_pulse bits asserted in one cycle SHALL increment all flagged digits in that same cycle.
REQ-021 sld_arith_pulse SHALL toggle op_sub in ENTRY_A and ENTRY_B only; ignored in COMPUTE and RESULT.
REQ-022 ENTRY_A + btn_ent_pulse: operand_a <= entry, entry <= 0, state -> ENTRY_B next cycle.
REQ-023 ENTRY_B + btn_ent_pulse: operand_b <= entry, entry <= 0, state -> COMPUTE; alu_start=1 for exactly the first COMPUTE cycle.
REQ-024 COMPUTE: cycle counter starts at 0 on entry; sld_digit_pulse, sld_arith_pulse, btn_ent_pulse ignored.
REQ-025 COMPUTE + alu_done (including the alu_start cycle): capture alu_result, error <= alu_overflow, state -> RESULT.
REQ-026 COMPUTE with no alu_done by counter = TIMEOUT_CYCLES-1: state -> RESULT, result <= 16'h0000, error <= 1.
REQ-027 alu_done outside COMPUTE SHALL be ignored (no capture, no state change).
REQ-028 RESULT + btn_ent_pulse: operand_a <= captured result, entry <= 0, error <= 0, state -> ENTRY_B (chained operation); op_sub retained.
REQ-029 btn_clr_pulse in any state: entry, operand_a, operand_b, result, op_sub, error <= 0; state -> ENTRY_A; alu_start deasserted; clear has priority over every other input in the same cycle.
REQ-030 btn_ent_pulse with sld_digit_pulse in the same cycle: digit increment applied first, incremented entry latched.
REQ-031 display_value: entry in ENTRY_A/ENTRY_B; operand_b in COMPUTE; result in RESULT with error=0; 16'hEEEE in RESULT with error=1.
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-033 reset=0 at a rising edge SHALL force state=ENTRY_A, operand_a=0, operand_b=0, op_sub=0, alu_start=0, error=0, display_value=0, entry=0, counter=0.
REQ-034 reset asserted mid-COMPUTE SHALL abandon the operation; a later alu_done SHALL be ignored.

Verification
REQ-035 Entry: 3 pulses bit0, 2 pulses bit1, ent -> operand_a=16'h0023, state=ENTRY_B, display_value=0.
REQ-036 Wrap: 10 pulses bit3 -> display_value=16'h0000; 11 pulses -> 16'h1000; neighbours unchanged.
REQ-037 Compute: A=0023, arith toggle, B=0011, ent -> alu_start one cycle, op_sub=1; alu_done with alu_result=16'h0012 after 3 cycles -> state=RESULT, display_value=16'h0012, error=0.
REQ-038 Timeout (TIMEOUT_CYCLES=4): no alu_done -> RESULT 4 cycles after COMPUTE entry, error=1, display_value=16'hEEEE.
REQ-039 Priority: btn_clr_pulse with btn_ent_pulse and sld_digit_pulse=4'b1111 in ENTRY_B -> ENTRY_A, all registers 0.
REQ-040 Chain: RESULT=0012, ent -> operand_a=16'h0012, state=ENTRY_B, error=0; reset mid-COMPUTE then alu_done -> state stays ENTRY_A.

Source files
------------

// File: rtl/calc_sequencer.sv
// Two-operand BCD calculator sequencer: digit entry, ALU handshake with timeout,
// result display and chained operation. All outputs come straight from flops.
module calc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_clr_pulse,
    input  logic        btn_ent_pulse,
    input  logic [3:0]  sld_digit_pulse,
    input  logic        sld_arith_pulse,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_overflow,
    output logic [15:0] operand_a,
    output logic [15:0] operand_b,
    output logic        op_sub,
    output logic        alu_start,
    output logic [15:0] display_value,
    output logic [1:0]  state,
    output logic        error
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        COMPUTE = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [15:0] operand_a_q, operand_a_d;
    logic [15:0] operand_b_q, operand_b_d;
    logic [15:0] result_q, result_d;
    logic [15:0] display_q, display_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        op_sub_q, op_sub_d;
    logic        alu_start_q, alu_start_d;
    logic        error_q, error_d;

    logic [15:0] entry_inc;
    logic        timeout_hit;

    // Per-digit mod-10 increment; digits never carry into their neighbour.
    function automatic logic [15:0] bump_digits(input logic [15:0] v, input logic [3:0] m);
        logic [15:0] r;
        r = v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (m[i]) begin
                r[4*i +: 4] = (v[4*i +: 4] >= 4'd9) ? 4'd0 : v[4*i +: 4] + 4'd1;
            end
        end
        return r;
    endfunction

    assign entry_inc   = bump_digits(entry_q, sld_digit_pulse);
    assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ENTRY_A;
            entry_q     <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            result_q    <= '0;
            display_q   <= '0;
            cnt_q       <= '0;
            op_sub_q    <= 1'b0;
            alu_start_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            result_q    <= result_d;
            display_q   <= display_d;
            cnt_q       <= cnt_d;
            op_sub_q    <= op_sub_d;
            alu_start_q <= alu_start_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (btn_clr_pulse) begin
            state_d = ENTRY_A;
        end else begin
            case (state_q)
                ENTRY_A: if (btn_ent_pulse) state_d = ENTRY_B;
                ENTRY_B: if (btn_ent_pulse) state_d = COMPUTE;
                COMPUTE: if (alu_done || timeout_hit) state_d = RESULT;
                RESULT:  if (btn_ent_pulse) state_d = ENTRY_B;
                default: state_d = ENTRY_A;
            endcase
        end
    end

    always_comb begin
        entry_d     = entry_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        result_d    = result_q;
        op_sub_d    = op_sub_q;
        error_d     = error_q;
        alu_start_d = 1'b0;
        cnt_d       = (state_q == COMPUTE && state_d == COMPUTE) ? cnt_q + 8'd1 : '0;

        if (btn_clr_pulse) begin
            entry_d     = '0;
            operand_a_d = '0;
            operand_b_d = '0;
            result_d    = '0;
            op_sub_d    = 1'b0;
            error_d     = 1'b0;
        end else begin
            case (state_q)
                ENTRY_A, ENTRY_B: begin
                    entry_d = entry_inc;
                    if (sld_arith_pulse) op_sub_d = ~op_sub_q;
                    if (btn_ent_pulse) begin
                        entry_d = '0;
                        if (state_q == ENTRY_A) begin
                            operand_a_d = entry_inc;
                        end else begin
                            operand_b_d = entry_inc;
                            alu_start_d = 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    // A late done on the final counted cycle still wins over the timeout.
                    if (alu_done) begin
                        result_d = alu_result;
                        error_d  = alu_overflow;
                    end else if (timeout_hit) begin
                        result_d = '0;
                        error_d  = 1'b1;
                    end
                end
                RESULT: begin
                    if (btn_ent_pulse) begin
                        operand_a_d = result_q;
                        entry_d     = '0;
                        error_d     = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        case (state_d)
            COMPUTE: display_d = operand_b_d;
            RESULT:  display_d = error_d ? 16'hEEEE : result_d;
            default: display_d = entry_d;
        endcase
    end

    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign op_sub        = op_sub_q;
    assign alu_start     = alu_start_q;
    assign display_value = display_q;
    assign state         = state_q;
    assign error         = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: digit-array reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_calc_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_clr_pulse, btn_ent_pulse, sld_arith_pulse, alu_done, alu_overflow;
    logic [3:0]  sld_digit_pulse;
    logic [15:0] alu_result;
    logic [15:0] operand_a, operand_b, display_value;
    logic        op_sub, alu_start, error;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    calc_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .btn_clr_pulse(btn_clr_pulse), .btn_ent_pulse(btn_ent_pulse),
        .sld_digit_pulse(sld_digit_pulse), .sld_arith_pulse(sld_arith_pulse),
        .alu_done(alu_done), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .operand_a(operand_a), .operand_b(operand_b), .op_sub(op_sub),
        .alu_start(alu_start), .display_value(display_value),
        .state(state), .error(error)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=A entry, 1=B entry, 2=compute, 3=result.
    int          m_mode = 0;
    int          m_dig[4] = '{0, 0, 0, 0};
    int          m_wait = 0;
    logic [15:0] m_a = '0, m_b = '0, m_res = '0;
    logic        m_sub = 1'b0, m_start = 1'b0, m_err = 1'b0;

    function automatic logic [15:0] pack_entry();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'(m_dig[i]);
        return v;
    endfunction

    function automatic logic [15:0] model_display();
        if (m_mode == 2) return m_b;
        if (m_mode == 3) return m_err ? 16'hEEEE : m_res;
        return pack_entry();
    endfunction

    task automatic model_step();
        m_start = 1'b0;
        if (!reset || btn_clr_pulse) begin
            m_mode = 0; m_wait = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            m_a = '0; m_b = '0; m_res = '0; m_sub = 1'b0; m_err = 1'b0;
        end else if (m_mode <= 1) begin
            for (int i = 0; i < 4; i++)
                if (sld_digit_pulse[i]) m_dig[i] = (m_dig[i] + 1) % 10;
            if (sld_arith_pulse) m_sub = !m_sub;
            if (btn_ent_pulse) begin
                if (m_mode == 0) begin
                    m_a = pack_entry(); m_mode = 1;
                end else begin
                    m_b = pack_entry(); m_mode = 2; m_start = 1'b1; m_wait = 0;
                end
                for (int i = 0; i < 4; i++) m_dig[i] = 0;
            end
        end else if (m_mode == 2) begin
            if (alu_done) begin
                m_res = alu_result; m_err = alu_overflow; m_mode = 3;
            end else if (m_wait == TO - 1) begin
                m_res = '0; m_err = 1'b1; m_mode = 3;
            end else begin
                m_wait++;
            end
        end else if (btn_ent_pulse) begin
            m_a = m_res; m_err = 1'b0; m_mode = 1;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        check("state", 16'(state), 16'(m_mode));
        check("operand_a", operand_a, m_a);
        check("operand_b", operand_b, m_b);
        check("op_sub", 16'(op_sub), 16'(m_sub));
        check("alu_start", 16'(alu_start), 16'(m_start));
        check("error", 16'(error), 16'(m_err));
        check("display", display_value, model_display());
    end

    // Apply one cycle of inputs starting at a negedge, then return them to idle.
    task automatic drive(input logic c, input logic e, input logic [3:0] d, input logic ar,
                         input logic dn, input logic [15:0] r, input logic o);
        btn_clr_pulse = c; btn_ent_pulse = e; sld_digit_pulse = d; sld_arith_pulse = ar;
        alu_done = dn; alu_result = r; alu_overflow = o;
        @(negedge clk);
        btn_clr_pulse = 0; btn_ent_pulse = 0; sld_digit_pulse = 0; sld_arith_pulse = 0;
        alu_done = 0; alu_result = '0; alu_overflow = 0;
    endtask

    task automatic digit(input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) drive(0, 0, d, 0, 0, '0, 0);
    endtask

    task automatic ent();
        drive(0, 1, 4'd0, 0, 0, '0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 0, 0, '0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        btn_clr_pulse = 0; btn_ent_pulse = 0; sld_digit_pulse = 0; sld_arith_pulse = 0;
        alu_done = 0; alu_result = '0; alu_overflow = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        check("lit_reset_state", 16'(state), 16'd0);
        check("lit_reset_disp", display_value, 16'h0000);

        // Entry of operand A = 0023
        digit(4'b0001, 3); digit(4'b0010, 2);
        check("lit_entry_disp", display_value, 16'h0023);
        ent();
        check("lit_entry_opa", operand_a, 16'h0023);
        check("lit_entry_state", 16'(state), 16'd1);
        check("lit_entry_disp0", display_value, 16'h0000);

        // Digit 3 wraps after ten pulses without touching neighbours
        digit(4'b1000, 10);
        check("lit_wrap10", display_value, 16'h0000);
        digit(4'b1000, 1);
        check("lit_wrap11", display_value, 16'h1000);
        digit(4'b0111, 1);
        check("lit_multi", display_value, 16'h1111);
        drive(1, 0, 4'd0, 0, 0, '0, 0);
        check("lit_clr_state", 16'(state), 16'd0);

        // 0023 - 0011 with done on the third compute cycle
        digit(4'b0001, 3); digit(4'b0010, 2); ent();
        drive(0, 0, 4'd0, 1, 0, '0, 0);
        digit(4'b0011, 1); ent();
        check("lit_start", 16'(alu_start), 16'd1);
        check("lit_opsub", 16'(op_sub), 16'd1);
        check("lit_opb", operand_b, 16'h0011);
        idle(1);
        check("lit_start_drop", 16'(alu_start), 16'd0);
        idle(1);
        drive(0, 0, 4'd0, 0, 1, 16'h0012, 0);
        check("lit_res_state", 16'(state), 16'd3);
        check("lit_res_disp", display_value, 16'h0012);
        check("lit_res_err", 16'(error), 16'd0);

        // Chain: result becomes operand A
        ent();
        check("lit_chain_opa", operand_a, 16'h0012);
        check("lit_chain_state", 16'(state), 16'd1);
        check("lit_chain_opsub", 16'(op_sub), 16'd1);

        // Timeout: no done for four compute cycles
        digit(4'b0001, 1); ent();
        idle(3);
        check("lit_to_wait", 16'(state), 16'd2);
        idle(1);
        check("lit_to_state", 16'(state), 16'd3);
        check("lit_to_err", 16'(error), 16'd1);
        check("lit_to_disp", display_value, 16'hEEEE);

        // Stray done in RESULT is ignored
        drive(0, 0, 4'd0, 0, 1, 16'h1234, 1);
        check("lit_stray_disp", display_value, 16'hEEEE);
        ent();
        check("lit_chain0_opa", operand_a, 16'h0000);
        check("lit_chain0_err", 16'(error), 16'd0);

        // Overflow reported on the alu_start cycle itself
        digit(4'b0101, 2); ent();
        drive(0, 0, 4'd0, 0, 1, 16'h9999, 1);
        check("lit_ovf_disp", display_value, 16'hEEEE);
        ent();

        // Clear beats enter, digits and arith in ENTRY_B
        drive(1, 1, 4'b1111, 1, 0, '0, 0);
        check("lit_prio_state", 16'(state), 16'd0);
        check("lit_prio_disp", display_value, 16'h0000);
        check("lit_prio_opa", operand_a, 16'h0000);
        check("lit_prio_opsub", 16'(op_sub), 16'd0);

        // Reset during COMPUTE abandons the operation
        ent(); ent();
        check("lit_rst_comp", 16'(state), 16'd2);
        reset = 0;
        @(negedge clk);
        reset = 1;
        drive(0, 0, 4'd0, 0, 1, 16'h0042, 0);
        check("lit_rst_state", 16'(state), 16'd0);
        check("lit_rst_disp", display_value, 16'h0000);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
